// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the I2C byte-FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef logic req_idx_t;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_BURST  = 4;

  function automatic state_t own_state(input req_idx_t idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/fifo_level_ctr.sv
// FIFO occupancy counter: up on write, down on valid pop, sticky underflow.
// FIFO_ARB_WMARK_EN adds a registered watermark flag that tracks the level register.
module fifo_level_ctr
  import fifo_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
`ifdef FIFO_ARB_WMARK_EN
  , parameter int WMARK = 6
`endif
) (
  input  logic                       w_clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       wr,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       underflow_err
`ifdef FIFO_ARB_WMARK_EN
  , output logic                     wmark_irq
`endif
);

  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] ONE      = LW'(1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [LW-1:0] level_nxt;
  logic          pop_ok;

  // A pop on an empty FIFO is dropped; a same-cycle write still counts.
  assign pop_ok = pop && (level != '0);
  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);

  always_comb begin
    level_nxt = level;
    if (clear)               level_nxt = '0;
    else if (wr && !pop_ok)  level_nxt = level + ONE;
    else if (!wr && pop_ok)  level_nxt = level - ONE;
  end

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      level         <= '0;
      underflow_err <= 1'b0;
    end else begin
      level <= level_nxt;
      if (clear)                      underflow_err <= 1'b0;
      else if (pop && level == '0)    underflow_err <= 1'b1;
    end
  end

`ifdef FIFO_ARB_WMARK_EN
  localparam logic [LW-1:0] WMARK_LVL = LW'(WMARK);

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) wmark_irq <= 1'b0;
    else        wmark_irq <= (level_nxt >= WMARK_LVL);
  end
`endif

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the FIFO write port between two requesters.
// Optional FIFO_ARB_WMARK_EN adds WMARK parameter and registered wmark_irq output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST  = DEF_BURST
`ifdef FIFO_ARB_WMARK_EN
  , parameter int WMARK = 6
`endif
) (
  input  logic                       w_clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       req0,
  input  logic                       req1,
  input  logic [DATA_W-1:0]          data0,
  input  logic [DATA_W-1:0]          data1,
  output logic                       gnt0,
  output logic                       gnt1,
  input  logic                       pop,
  output logic [DATA_W-1:0]          fifo_w_data,
  output logic                       fifo_w_enable,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       underflow_err
`ifdef FIFO_ARB_WMARK_EN
  , output logic                     wmark_irq
`endif
);

  localparam int CW = $clog2(BURST+1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST-1);

  logic [1:0]             req;
  logic [1:0][DATA_W-1:0] data;
  state_t                 state, state_nxt;
  req_idx_t               rr_last, rr_last_nxt, own;
  logic [CW-1:0]          beat_cnt, beat_cnt_nxt;
  logic                   owning, beat, release_own;

  assign req  = {req1, req0};
  assign data = {data1, data0};

  assign owning        = (state == OWN0) || (state == OWN1);
  assign own           = (state == OWN1);
  assign gnt0          = (state == OWN0) && !full;
  assign gnt1          = (state == OWN1) && !full;
  assign beat          = owning && req[own] && !full;
  assign fifo_w_enable = beat;
  assign fifo_w_data   = data[own];

  always_comb begin
    state_nxt    = state;
    rr_last_nxt  = rr_last;
    beat_cnt_nxt = beat_cnt;
    release_own  = 1'b0;
    case (state)
      IDLE: begin
        if (&req)        state_nxt = own_state(~rr_last);
        else if (req[0]) state_nxt = OWN0;
        else if (req[1]) state_nxt = OWN1;
      end
      default: begin
        // While full, beat stays low so only a dropped request can release.
        release_own = !req[own] || (beat && beat_cnt == LAST_BEAT);
        if (release_own) begin
          rr_last_nxt  = own;
          beat_cnt_nxt = '0;
          if (req[~own])     state_nxt = own_state(~own);
          else if (req[own]) state_nxt = state;
          else               state_nxt = IDLE;
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      beat_cnt <= '0;
    end else if (clear) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  fifo_level_ctr #(
    .DEPTH(DEPTH)
`ifdef FIFO_ARB_WMARK_EN
    , .WMARK(WMARK)
`endif
  ) u_level (
    .w_clk         (w_clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .wr            (beat),
    .pop           (pop),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .underflow_err (underflow_err)
`ifdef FIFO_ARB_WMARK_EN
    , .wmark_irq   (wmark_irq)
`endif
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, corner sequences, random vs reference model.
module tb_fifo_wr_arbiter;

  localparam int DEPTH = 8;
  localparam int BURST = 4;
`ifdef FIFO_ARB_WMARK_EN
  localparam int WMARK = 6;
`endif

  logic       w_clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clear = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, pop = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic [7:0] fifo_w_data;
  logic       gnt0, gnt1, fifo_w_enable, full, empty, underflow_err;
  logic [3:0] level;
`ifdef FIFO_ARB_WMARK_EN
  logic       wmark_irq;
`endif

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter dut (
    .w_clk         (w_clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .req0          (req0),
    .req1          (req1),
    .data0         (data0),
    .data1         (data1),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .pop           (pop),
    .fifo_w_data   (fifo_w_data),
    .fifo_w_enable (fifo_w_enable),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .underflow_err (underflow_err)
`ifdef FIFO_ARB_WMARK_EN
    , .wmark_irq   (wmark_irq)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the port (-1 = nobody), beats used from the quota,
  // last owner for round robin, occupancy and the sticky underflow flag.
  int m_own, m_cnt, m_last, m_lvl;
  bit m_uf;

  // Values seen mid-cycle by the last step() call.
  bit obs_g0, obs_g1, obs_we, obs_full;
  int obs_wd, obs_lvl;

  typedef struct {
    bit         r0;
    logic [7:0] d0;
    bit         g0;
    bit         we;
    logic [7:0] wd;
    int         lvl;
  } vec_t;
  vec_t t2 [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_last = 1; m_lvl = 0; m_uf = 0;
  endtask

  // One clock cycle: drive, check mid-cycle against model, advance model on the edge.
  task automatic step(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1,
                      input bit p, input bit c);
    bit [1:0] r;
    bit g0, g1, we, vpop;
    int wd;
    r = {r1, r0};
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; pop = p; clear = c;
    #2;
    g0 = (m_own == 0) && (m_lvl < DEPTH);
    g1 = (m_own == 1) && (m_lvl < DEPTH);
    we = (m_own >= 0) && r[m_own] && (m_lvl < DEPTH);
    wd = (m_own == 1) ? int'(d1) : int'(d0);
    obs_g0 = gnt0; obs_g1 = gnt1; obs_we = fifo_w_enable; obs_full = full;
    obs_wd = int'(fifo_w_data); obs_lvl = int'(level);
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("w_enable", fifo_w_enable, we);
    if (we) chk("w_data", fifo_w_data, wd);
    chk("level", level, m_lvl);
    chk("full", full, m_lvl == DEPTH);
    chk("empty", empty, m_lvl == 0);
    chk("underflow", underflow_err, m_uf);
    chk("wr_when_full", fifo_w_enable & full, 0);
`ifdef FIFO_ARB_WMARK_EN
    chk("wmark", wmark_irq, m_lvl >= WMARK);
`endif
    @(posedge w_clk);
    if (c) model_reset();
    else begin
      vpop = p && (m_lvl > 0);
      if (p && m_lvl == 0) m_uf = 1;
      m_lvl = m_lvl + (we ? 1 : 0) - (vpop ? 1 : 0);
      if (m_own < 0) begin
        if (r0 && r1)  m_own = 1 - m_last;
        else if (r0)   m_own = 0;
        else if (r1)   m_own = 1;
      end else if (!r[m_own] || (we && m_cnt == BURST-1)) begin
        int o;
        o = m_own; m_last = o; m_cnt = 0;
        if (r[1-o])     m_own = 1 - o;
        else if (!r[o]) m_own = -1;
      end else if (we) m_cnt++;
    end
    #1;
  endtask

  initial begin
    int exp_own;
    model_reset();
    t2 = '{'{1, 8'hA1, 0, 0, 8'h00, 0},
           '{1, 8'hA1, 1, 1, 8'hA1, 0},
           '{1, 8'hA2, 1, 1, 8'hA2, 1},
           '{1, 8'hA3, 1, 1, 8'hA3, 2},
           '{0, 8'h00, 1, 0, 8'h00, 3},
           '{0, 8'h00, 0, 0, 8'h00, 3}};

    // Reset state while n_rst is held low
    #12;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_we", fifo_w_enable, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_uf", underflow_err, 0);
    n_rst = 1'b1;

    // T2: single requester, three beats
    for (int i = 0; i < 6; i++) begin
      step(t2[i].r0, 1'b0, t2[i].d0, 8'h00, 1'b0, 1'b0);
      chk("t2_gnt0", obs_g0, t2[i].g0);
      chk("t2_we", obs_we, t2[i].we);
      if (t2[i].we) chk("t2_data", obs_wd, t2[i].wd);
      chk("t2_level", obs_lvl, t2[i].lvl);
    end

    // T3: both requesting, owner order 0,1,0 with BURST beats each, no gaps
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c <= 12; c++) begin
      step(1'b1, 1'b1, 8'(8'h10 + c), 8'(8'h20 + c), c >= 2, 1'b0);
      exp_own = (c == 0) ? -1 : ((c - 1) / BURST) % 2;
      chk("t3_we", obs_we, c > 0);
      chk("t3_gnt0", obs_g0, exp_own == 0);
      chk("t3_gnt1", obs_g1, exp_own == 1);
      if (exp_own >= 0) chk("t3_data", obs_wd, (exp_own == 0) ? 8'h10 + c : 8'h20 + c);
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // T4: fill to DEPTH, stall while full, one pop frees a slot
    for (int c = 0; c <= DEPTH; c++) step(1'b1, 1'b0, 8'(8'h30 + c), 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b0);
    chk("t4_full", obs_full, 1);
    chk("t4_gnt_stall", obs_g0, 0);
    chk("t4_we_stall", obs_we, 0);
    step(1'b1, 1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
    chk("t4_level_after_pop", level, DEPTH - 1);
    step(1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b0);
    chk("t4_resume_gnt", obs_g0, 1);
    chk("t4_resume_we", obs_we, 1);
    chk("t4_refull", level, DEPTH);

    // T5: underflow sticky until clear
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("t5_uf_set", underflow_err, 1);
    chk("t5_level", level, 0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("t5_uf_sticky", underflow_err, 1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t5_uf_clear", underflow_err, 0);

    // T6: write and pop in the same cycle hold the level
    for (int c = 0; c <= 5; c++) step(1'b1, 1'b0, 8'(8'h50 + c), 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0);
    chk("t6_level_hold", level, 5);
    step(1'b1, 1'b0, 8'h5B, 8'h00, 1'b0, 1'b0);
    chk("t6_level_6", level, 6);
`ifdef FIFO_ARB_WMARK_EN
    chk("t6_wmark_set", wmark_irq, 1);
`endif
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("t6_level_5", level, 5);
`ifdef FIFO_ARB_WMARK_EN
    chk("t6_wmark_clr", wmark_irq, 0);
`endif

    // T1: asynchronous reset in the middle of a burst
    step(1'b1, 1'b0, 8'h61, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h62, 8'h00, 1'b0, 1'b0);
    req0 = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("t1_gnt0", gnt0, 0);
    chk("t1_we", fifo_w_enable, 0);
    chk("t1_level", level, 0);
    chk("t1_empty", empty, 1);
    chk("t1_full", full, 0);
    model_reset();
    @(posedge w_clk);
    #1;
    chk("t1_level_edge", level, 0);
    chk("t1_empty_edge", empty, 1);
    n_rst = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           8'($urandom), 8'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
